// File: rtl/niosii_pio_led_pwm_if.sv
// rtl/niosii_pio_led_pwm_if.sv - Avalon-MM register bus for the LED PIO/PWM block
//
// Purpose: groups the zero-wait-state Avalon-MM slave signals.
// Signals:
//   address     3-bit word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   32-bit write data
//   readdata    32-bit read data, combinational from address
// Modports: master drives the request, slave returns readdata.
interface niosii_pio_led_pwm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_pio_led_pwm.sv
// rtl/niosii_pio_led_pwm.sv - LED PIO with per-channel blink and global PWM dimming
//
// Purpose: Avalon-MM PIO whose output channels combine a data register,
// a shared blink phase and a shared 255-cycle PWM duty.
// Ports:
//   clk       single clock, all state changes on its rising edge
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   out_port  registered channel drive, WIDTH bits
// Register map (word address):
//   0 DATA  1 SET (W1S)  2 CLEAR (W1C)  3 BLINK_EN  4 BLINK_PERIOD
//   5 DUTY  6 STATUS (bit0 = phase)  7 reserved
module niosii_pio_led_pwm #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE_W  = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  niosii_pio_led_pwm_if.slave   bus,
  output logic [WIDTH-1:0]      out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam logic [7:0] PWM_LAST = 8'd254;

  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      blink_en_q;
  logic [PRESCALE_W-1:0] blink_period_q;
  logic [7:0]            duty_q;
  logic                  phase_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [7:0]            pwm_cnt_q;

  logic                  wr_en;
  logic [WIDTH-1:0]      wd_ch;
  logic [PRESCALE_W-1:0] wd_period;
  logic [7:0]            wd_duty;
  logic                  pwm_on;
  logic [WIDTH-1:0]      ch;
  logic [31:0]           readdata_c;
  logic                  unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd_ch     = bus.writedata[WIDTH-1:0];
  assign wd_period = bus.writedata[PRESCALE_W-1:0];
  assign wd_duty   = bus.writedata[7:0];
  // Upper writedata bits are architecturally ignored.
  assign unused_wd = ^bus.writedata;

  // DATA: direct write, set-bits and clear-bits share one register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DATA:  data_q <= wd_ch;
        ADDR_SET:   data_q <= data_q | wd_ch;
        ADDR_CLEAR: data_q <= data_q & ~wd_ch;
        default:    data_q <= data_q;
      endcase
    end
  end

  // Plain read/write configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_en_q     <= '0;
      blink_period_q <= '0;
      duty_q         <= 8'hFF;
    end else if (wr_en) begin
      if (bus.address == ADDR_BLINK)  blink_en_q     <= wd_ch;
      if (bus.address == ADDR_PERIOD) blink_period_q <= wd_period;
      if (bus.address == ADDR_DUTY)   duty_q         <= wd_duty;
    end
  end

  // Blink prescaler. A period write restarts the blink with phase on, so
  // software sees a full "on" half-period right after reprogramming.
  // A zero period parks the counter and holds the channels unblinked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      phase_q <= 1'b1;
    end else if (wr_en && bus.address == ADDR_PERIOD) begin
      presc_q <= wd_period;
      phase_q <= 1'b1;
    end else if (blink_period_q == '0) begin
      presc_q <= '0;
      phase_q <= 1'b1;
    end else if (presc_q == '0) begin
      presc_q <= blink_period_q;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q - PRESCALE_W'(1);
    end
  end

  // PWM counter spans 0..254 so that DUTY=255 compares true on every count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty_q);
  assign ch     = data_q & (~blink_en_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};

  // Output register: drive follows register state one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= ch;
    end
  end

  // Zero-wait-state read mux, independent of chipselect.
  always_comb begin
    readdata_c = '0;
    case (bus.address)
      ADDR_DATA:   readdata_c = 32'(data_q);
      ADDR_BLINK:  readdata_c = 32'(blink_en_q);
      ADDR_PERIOD: readdata_c = 32'(blink_period_q);
      ADDR_DUTY:   readdata_c = 32'(duty_q);
      ADDR_STATUS: readdata_c = {31'd0, phase_q};
      default:     readdata_c = '0;
    endcase
  end

  assign bus.readdata = readdata_c;

endmodule

// File: tb/tb_niosii_pio_led_pwm.sv
// tb/tb_niosii_pio_led_pwm.sv - scoreboard bench for niosii_pio_led_pwm
module tb_niosii_pio_led_pwm;

  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_HI  = 2;
  localparam int K_LO  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    string       name;
    logic [31:0] exp;
  } item_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;

  niosii_pio_led_pwm_if bus ();

  niosii_pio_led_pwm #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .PRESCALE_W  (24)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    hi_cnt = 0;
  int    lo_cnt = 0;
  bit    win_en = 1'b0;
  item_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts PWM window samples, then retires every expectation
  // stamped for this cycle against the live DUT outputs.
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    if (win_en) begin
      if (out_port == 8'hFF) hi_cnt++;
      else if (out_port == 8'h00) lo_cnt++;
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      case (it.kind)
        K_RD:    act = bus.readdata;
        K_OUT:   act = {24'h0, out_port};
        K_HI:    act = 32'(hi_cnt);
        default: act = 32'(lo_cnt);
      endcase
      n_chk++;
      if (it.cyc != cyc || act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h required %h (stamped cycle %0d, checked cycle %0d)",
                 it.name, act, it.exp, it.cyc, cyc);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int kind, string name, logic [31:0] exp);
    item_t it;
    it.kind = kind;
    it.cyc  = cyc;
    it.name = name;
    it.exp  = exp;
    q.push_back(it);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(string name, logic [2:0] a, logic [31:0] exp);
    bus.address = a;
    push(K_RD, name, exp);
    step();
  endtask

  task automatic out(string name, logic [7:0] exp);
    push(K_OUT, name, {24'h0, exp});
  endtask

  task automatic window(string name, int hi, int lo);
    hi_cnt = 0;
    lo_cnt = 0;
    win_en = 1'b1;
    step(255);
    win_en = 1'b0;
    push(K_HI, {name, "_hi"}, 32'(hi));
    push(K_LO, {name, "_lo"}, 32'(lo));
    step();
  endtask

  function automatic logic exp_ph(int k);
    if (k < 0) return 1'b1;
    return ((k / 4) % 2) == 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    step(3);

    // Reset values and first edge after release.
    out("rst_out", 8'h00);
    rd("rst_data", 3'd0, 32'hA5);
    rd("rst_duty", 3'd5, 32'hFF);
    rd("rst_status", 3'd6, 32'h1);
    reset_n = 1'b1;
    out("rel_out", 8'h00);
    step();
    out("first_edge", 8'hA5);
    rd("post_rel_data", 3'd0, 32'hA5);

    // DATA / SET / CLEAR sequence.
    wr(3'd0, 32'h0F);
    wr(3'd1, 32'hF0);
    wr(3'd2, 32'h3C);
    out("clr_lag", 8'hFF);
    rd("clr_data", 3'd0, 32'hC3);
    out("clr_out", 8'hC3);
    rd("set_rd0", 3'd1, 32'h0);
    rd("clr_rd0", 3'd2, 32'h0);

    // Writes without chipselect and to the reserved address are ignored.
    bus.address    = 3'd0;
    bus.writedata  = 32'h0;
    bus.write_n    = 1'b0;
    step();
    bus.write_n    = 1'b1;
    rd("nocs_data", 3'd0, 32'hC3);
    wr(3'd7, 32'hFFFF_FFFF);
    rd("rsv_rd", 3'd7, 32'h0);
    rd("rsv_data", 3'd0, 32'hC3);

    // Blink with period 3: phase holds 4 cycles each way.
    wr(3'd0, 32'hFF);
    wr(3'd3, 32'h01);
    wr(3'd4, 32'h3);
    for (int k = 0; k < 16; k++) begin
      out($sformatf("blink_out%0d", k), {7'h7F, exp_ph(k - 1)});
      rd($sformatf("blink_st%0d", k), 3'd6, {31'h0, exp_ph(k)});
    end

    // Period rewrite in the off half-phase restarts with phase on.
    step(5);
    rd("pre_bp_st", 3'd6, 32'h0);
    wr(3'd4, 32'd100);
    rd("bp_restart", 3'd6, 32'h1);
    step(99);
    rd("bp_hold", 3'd6, 32'h1);
    rd("bp_toggle", 3'd6, 32'h0);
    rd("bp_rd", 3'd4, 32'd100);
    wr(3'd4, 32'h0);
    rd("bp0_st_a", 3'd6, 32'h1);
    step(7);
    out("bp0_out", 8'hFF);
    rd("bp0_st_b", 3'd6, 32'h1);
    wr(3'd3, 32'h00);

    // PWM duty windows over one full 255-cycle period.
    wr(3'd5, 32'd64);
    step();
    window("duty64", 64, 191);
    wr(3'd5, 32'd0);
    step();
    out("duty0_out", 8'h00);
    window("duty0", 0, 255);
    wr(3'd5, 32'd255);
    step();
    out("duty255_out", 8'hFF);
    window("duty255", 255, 0);

    // Upper writedata bits are dropped.
    wr(3'd0, 32'hFFFF_FF5A);
    rd("trunc_data", 3'd0, 32'h5A);
    wr(3'd3, 32'hABCD_EF03);
    rd("trunc_blink", 3'd3, 32'h03);
    wr(3'd4, 32'hFF00_0005);
    rd("trunc_period", 3'd4, 32'h5);
    wr(3'd5, 32'h1234_5680);
    rd("trunc_duty", 3'd5, 32'h80);

    // Asynchronous reset mid blink and PWM, checked before any clock edge.
    step(37);
    reset_n = 1'b0;
    out("async_out", 8'h00);
    rd("async_data", 3'd0, 32'hA5);
    rd("async_blink", 3'd3, 32'h0);
    rd("async_period", 3'd4, 32'h0);
    rd("async_duty", 3'd5, 32'hFF);
    rd("async_status", 3'd6, 32'h1);
    reset_n = 1'b1;
    out("rel2_out", 8'h00);
    step();
    out("rel2_first", 8'hA5);
    step();

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks still pending, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
